multicycle_ctrl: RTL

- Main control FSM for the multi-cycle MIPS-subset CPU.
- Sequences the shared datapath (PC, IR, register file, single ALU, data memory) over IF/ID/EX/MEM/WB steps.
- Decodes op/funct from the IR. Handles a wait-state handshake from data memory.
- Supported: R-type add/sub/subu/slt/sltu, ori, addiu, lw, sw, beq, j. An all-zero word is a NOP.

---
 rtl/multicycle_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS-subset CPU: steps the shared datapath
// through IF/ID/EX/MEM/WB, decodes op/funct and handles the data-memory wait handshake.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             mem_re,
    output logic             mem_we,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_zero,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,  S_ID  = 4'd1,  S_EXR = 4'd2,  S_EXI = 4'd3,
        S_MADR = 4'd4,  S_MRD = 4'd5,  S_MWR = 4'd6,  S_WBR = 4'd7,
        S_WBI  = 4'd8,  S_WBL = 4'd9,  S_BEQ = 4'd10, S_JMP = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       mem_re;
        logic       mem_we;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_SLTU = 3'b100;
    localparam logic [2:0] ALU_SUBU = 3'b101;

    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_TIMEOUT - 1);

    state_t     cur_state;
    state_t     next_state;
    ctrl_t      ctrl_q;
    logic [3:0] wait_cnt;
    logic       retire;
    logic       illegal_c;
    logic       in_mem;

    function automatic logic funct_valid(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_SUBU) || (f == F_SLT) || (f == F_SLTU);
    endfunction

    function automatic logic [2:0] r_alu_op(input logic [5:0] f);
        case (f)
            F_SUB:   return ALU_SUB;
            F_SUBU:  return ALU_SUBU;
            F_SLT:   return ALU_SLT;
            F_SLTU:  return ALU_SLTU;
            default: return ALU_ADD;
        endcase
    endfunction

    // Control word for the state being entered; op/funct come from the stable IR.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] o, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF:   begin c.pc_we = 1'b1; c.ir_we = 1'b1; c.alu_src_b = 2'b01; end
            S_ID:   c.alu_src_b = 2'b11;
            S_EXR:  begin c.alu_src_a = 1'b1; c.alu_op = r_alu_op(f); end
            S_WBR:  begin c.reg_we = 1'b1; c.reg_dst = 1'b1; c.alu_op = r_alu_op(f); end
            S_EXI:  begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.ext_zero  = (o == OP_ORI);
                c.alu_op    = (o == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_WBI:  c.reg_we = 1'b1;
            S_MADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MRD:  c.mem_re = 1'b1;
            S_MWR:  c.mem_we = 1'b1;
            S_WBL:  begin c.reg_we = 1'b1; c.mem_to_reg = 1'b1; end
            S_BEQ:  begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = 2'b01; end
            S_JMP:  begin c.pc_we = 1'b1; c.pc_src = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    assign in_mem = (cur_state == S_MRD) || (cur_state == S_MWR);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = cur_state;
        retire     = 1'b0;
        illegal_c  = 1'b0;
        case (cur_state)
            S_IF: next_state = S_ID;
            S_ID: begin
                next_state = S_IF;
                case (op)
                    OP_RTYPE: begin
                        if (funct == 6'b000000)   retire = 1'b1;
                        else if (funct_valid(funct)) next_state = S_EXR;
                        else                      illegal_c = 1'b1;
                    end
                    OP_ORI, OP_ADDIU: next_state = S_EXI;
                    OP_LW, OP_SW:     next_state = S_MADR;
                    OP_BEQ:           next_state = S_BEQ;
                    OP_J:             next_state = S_JMP;
                    default:          illegal_c = 1'b1;
                endcase
            end
            S_EXR:  next_state = S_WBR;
            S_EXI:  next_state = S_WBI;
            S_MADR: next_state = (op == OP_LW) ? S_MRD : S_MWR;
            S_MRD, S_MWR: begin
                if (mem_ready) begin
                    next_state = (cur_state == S_MRD) ? S_WBL : S_IF;
                    retire     = (cur_state == S_MWR);
                end else if (wait_cnt == WAIT_LIMIT) begin
                    next_state = S_IF;
                    illegal_c  = 1'b1;
                end
            end
            S_WBR, S_WBI, S_WBL, S_BEQ, S_JMP: begin
                next_state = S_IF;
                retire     = 1'b1;
            end
            default: next_state = S_IF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IF;
            ctrl_q    <= ctrl_for(S_IF, op, funct);
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            cur_state <= next_state;
            ctrl_q    <= ctrl_for(next_state, op, funct);
            wait_cnt  <= (in_mem && next_state == cur_state) ? wait_cnt + 4'd1 : 4'd0;
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    // Write strobes are gated by rst so nothing is committed during a reset cycle.
    assign pc_we      = ~rst & ((cur_state == S_BEQ) ? zero : ctrl_q.pc_we);
    assign ir_we      = ~rst & ctrl_q.ir_we;
    assign reg_we     = ~rst & ctrl_q.reg_we;
    assign mem_re     = ~rst & ctrl_q.mem_re;
    assign mem_we     = ~rst & ctrl_q.mem_we;
    assign illegal    = ~rst & illegal_c;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign ext_zero   = ctrl_q.ext_zero;
    assign alu_op     = ctrl_q.alu_op;
    assign pc_src     = ctrl_q.pc_src;
    assign state      = cur_state;

endmodule
